// File: rtl/ssram_arbiter.sv
// Two-master (CPU/VGA) round-robin Wishbone arbiter in front of the SSRAM controller.
// Optional per-tenure ack limit: define SSRAM_ARB_BURST_LIMIT_EN.
module ssram_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned AW        = 22
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          cpu_cyc_i,
    input  logic [AW-1:0] cpu_adr_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic          cpu_we_i,
    input  logic [31:0]   cpu_dat_i,
    output logic          cpu_ack_o,

    input  logic          vga_cyc_i,
    input  logic [AW-1:0] vga_adr_i,
    input  logic [3:0]    vga_sel_i,
    input  logic          vga_we_i,
    input  logic [31:0]   vga_dat_i,
    output logic          vga_ack_o,

    output logic          cyc_o,
    output logic          stb_o,
    output logic [AW-1:0] adr_o,
    output logic [3:0]    sel_o,
    output logic          we_o,
    output logic [31:0]   dat_o,
    input  logic          ack_i,

    output logic          cpu_gnt,
    output logic          vga_gnt
);

    typedef enum logic [1:0] {
        StIdle,
        StCpu,
        StVga
    } state_e;

    localparam logic OwnerCpu = 1'b0;
    localparam logic OwnerVga = 1'b1;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..255");
    end

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   limit_cpu, limit_vga;

`ifdef SSRAM_ARB_BURST_LIMIT_EN
    logic [7:0] ack_cnt_q, ack_cnt_d;
    logic       limit_hit;

    assign limit_hit = ack_i && (ack_cnt_q == 8'(MAX_BURST - 1));
    assign limit_cpu = limit_hit && vga_cyc_i;
    assign limit_vga = limit_hit && cpu_cyc_i;

    // Counts acks within one tenure; cleared on every grant change, saturates at 255.
    always_comb begin
        ack_cnt_d = ack_cnt_q;
        if (state_d != state_q) begin
            ack_cnt_d = 8'd0;
        end else if (ack_i && state_q != StIdle && ack_cnt_q != 8'hFF) begin
            ack_cnt_d = ack_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_cnt_q <= 8'd0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
        end
    end
`else
    assign limit_cpu = 1'b0;
    assign limit_vga = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_cyc_i && vga_cyc_i) begin
                    state_d = (last_owner_q == OwnerVga) ? StCpu : StVga;
                end else if (cpu_cyc_i) begin
                    state_d = StCpu;
                end else if (vga_cyc_i) begin
                    state_d = StVga;
                end
            end
            StCpu: begin
                if (!cpu_cyc_i) begin
                    state_d = vga_cyc_i ? StVga : StIdle;
                end else if (limit_cpu) begin
                    state_d = StVga;
                end
            end
            StVga: begin
                if (!vga_cyc_i) begin
                    state_d = cpu_cyc_i ? StCpu : StIdle;
                end else if (limit_vga) begin
                    state_d = StCpu;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A tenure starts whenever the next state is a grant state different from the current one.
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_d != state_q) begin
            if (state_d == StCpu) begin
                last_owner_d = OwnerCpu;
            end else if (state_d == StVga) begin
                last_owner_d = OwnerVga;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_owner_q <= OwnerCpu;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign cpu_gnt   = (state_q == StCpu);
    assign vga_gnt   = (state_q == StVga);

    assign cpu_ack_o = ack_i & cpu_gnt;
    assign vga_ack_o = ack_i & vga_gnt;

    assign cyc_o     = (cpu_gnt & cpu_cyc_i) | (vga_gnt & vga_cyc_i);
    assign stb_o     = cyc_o;

    assign adr_o     = vga_gnt ? vga_adr_i : cpu_adr_i;
    assign sel_o     = vga_gnt ? vga_sel_i : cpu_sel_i;
    assign we_o      = vga_gnt ? vga_we_i  : cpu_we_i;
    assign dat_o     = vga_gnt ? vga_dat_i : cpu_dat_i;

endmodule
